// File: rtl/fir_direct_param.sv
`default_nettype none
// ============================================================================
// fir_direct_param : parametrised direct-form FIR with double-buffered banks
// Revision 1.0 - initial release
// ============================================================================
module fir_direct_param #(
    parameter int TAPS   = 33,
    parameter int DIN_W  = 3,
    parameter int COEF_W = 16,
    parameter int DOUT_W = 16,
    parameter int SHIFT  = 0,
    parameter int ADDR_W = 6
) (
    input  logic                     iClk_12M,
    input  logic                     iRst,
    input  logic                     iCoeffiUpdateFlag,
    input  logic                     iCsnRam,
    input  logic                     iWrnRam,
    input  logic [ADDR_W-1:0]        iAddrRam,
    input  logic signed [COEF_W-1:0] iWrDtRam,
    output logic signed [COEF_W-1:0] oRdDtRam,
    output logic                     oAddrErr,
    output logic                     oBusy,
    input  logic                     iInValid,
    input  logic signed [DIN_W-1:0]  iFirIn,
    output logic                     oOutValid,
    output logic signed [DOUT_W-1:0] oFirOut
);

    localparam int ACC_W = DIN_W + COEF_W + $clog2(TAPS);
    localparam int CW    = (ACC_W + 2 > DOUT_W + 1) ? ACC_W + 2 : DOUT_W + 1;

    localparam logic [ADDR_W:0]       TAPS_A  = (ADDR_W + 1)'(TAPS);
    localparam logic signed [CW-1:0]  RND     = (SHIFT > 0) ? (CW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [CW-1:0]  SAT_MAX = (CW'(1) << (DOUT_W - 1)) - CW'(1);
    localparam logic signed [CW-1:0]  SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t state;

    logic signed [COEF_W-1:0] shadow [TAPS];
    logic signed [COEF_W-1:0] active [TAPS];
    logic signed [DIN_W-1:0]  dline  [TAPS];
    logic signed [ACC_W-1:0]  prod   [TAPS];

    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  acc;
    logic                     s1_valid;
    logic                     s2_valid;
    logic                     addr_ok;

    logic signed [CW-1:0]     acc_ext;
    logic signed [CW-1:0]     rounded;
    logic signed [CW-1:0]     shifted;
    logic signed [DOUT_W-1:0] sat;

    assign addr_ok = ({1'b0, iAddrRam} < TAPS_A);

    // Bus FSM and coefficient banks
    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            state    <= ST_RUN;
            oBusy    <= 1'b0;
            oRdDtRam <= '0;
            oAddrErr <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            oAddrErr <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (iCoeffiUpdateFlag) begin
                        state <= ST_LOAD;
                        oBusy <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!iCsnRam) begin
                        if (addr_ok) begin
                            if (!iWrnRam)
                                shadow[iAddrRam] <= iWrDtRam;
                            else
                                oRdDtRam <= shadow[iAddrRam];
                        end else begin
                            oAddrErr <= 1'b1;
                        end
                    end
                    if (!iCoeffiUpdateFlag)
                        state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    for (int i = 0; i < TAPS; i++)
                        active[i] <= shadow[i];
                    state <= ST_RUN;
                    oBusy <= 1'b0;
                end
                default: begin
                    state <= ST_RUN;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < TAPS; i++)
                dline[i] <= '0;
        end else if (iInValid) begin
            dline[0] <= iFirIn;
            for (int i = 1; i < TAPS; i++)
                dline[i] <= dline[i-1];
        end
    end

    // During COMMIT the shadow bank is already the new bank, so the sample
    // multiplied at the commit edge sees the new coefficients on every tap.
    generate
        for (genvar i = 0; i < TAPS; i++) begin : g_tap
            logic signed [COEF_W-1:0] coef;
            assign coef    = (state == ST_COMMIT) ? shadow[i] : active[i];
            assign prod[i] = {{(ACC_W - COEF_W){coef[COEF_W-1]}}, coef}
                           * {{(ACC_W - DIN_W){dline[i][DIN_W-1]}}, dline[i]};
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int i = 0; i < TAPS; i++)
            sum = sum + prod[i];
    end

    always_comb begin
        acc_ext = {{(CW - ACC_W){acc[ACC_W-1]}}, acc};
        rounded = acc_ext + RND;
        shifted = rounded >>> SHIFT;
        if (shifted > SAT_MAX)
            sat = SAT_MAX[DOUT_W-1:0];
        else if (shifted < SAT_MIN)
            sat = SAT_MIN[DOUT_W-1:0];
        else
            sat = shifted[DOUT_W-1:0];
    end

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            acc       <= '0;
            oFirOut   <= '0;
            oOutValid <= 1'b0;
        end else begin
            s1_valid  <= iInValid;
            s2_valid  <= s1_valid;
            oOutValid <= s2_valid;
            if (s1_valid)
                acc <= sum;
            if (s2_valid)
                oFirOut <= sat;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_direct_param.sv
`default_nettype none
// ============================================================================
// tb_fir_direct_param : directed bench for fir_direct_param
// Revision 1.0 - initial release
// ============================================================================
module tb_fir_direct_param;

    localparam int TAPS = 33;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flag = 1'b0;
    logic csn = 1'b1;
    logic wrn = 1'b1;
    logic [5:0] addr = '0;
    logic signed [15:0] wdata = '0;
    logic in_valid = 1'b0;
    logic signed [2:0] fir_in = '0;

    logic signed [15:0] rd_dt, rd_dt2;
    logic addr_err, addr_err2, busy, busy2, out_valid, out_valid2;
    logic signed [15:0] fir_out, fir_out2;

    always #5 clk = ~clk;

    fir_direct_param #(.TAPS(33), .DIN_W(3), .COEF_W(16), .DOUT_W(16), .SHIFT(0), .ADDR_W(6)) dut (
        .iClk_12M(clk), .iRst(rst), .iCoeffiUpdateFlag(flag), .iCsnRam(csn), .iWrnRam(wrn),
        .iAddrRam(addr), .iWrDtRam(wdata), .oRdDtRam(rd_dt), .oAddrErr(addr_err), .oBusy(busy),
        .iInValid(in_valid), .iFirIn(fir_in), .oOutValid(out_valid), .oFirOut(fir_out));

    fir_direct_param #(.TAPS(33), .DIN_W(3), .COEF_W(16), .DOUT_W(16), .SHIFT(2), .ADDR_W(6)) dut_shift (
        .iClk_12M(clk), .iRst(rst), .iCoeffiUpdateFlag(flag), .iCsnRam(csn), .iWrnRam(wrn),
        .iAddrRam(addr), .iWrDtRam(wdata), .oRdDtRam(rd_dt2), .oAddrErr(addr_err2), .oBusy(busy2),
        .iInValid(in_valid), .iFirIn(fir_in), .oOutValid(out_valid2), .oFirOut(fir_out2));

    int n_chk = 0;
    int n_err = 0;

    // Stream settings applied on every cycle and the two-deep expectation pipe
    logic cur_v = 1'b0;
    logic signed [2:0] cur_s = '0;
    logic cur_care = 1'b0;
    int cur_ev = 0;
    logic sel = 1'b0;
    logic q1_v = 1'b0, q1_c = 1'b0, q2_v = 1'b0, q2_c = 1'b0;
    int q1_e = 0, q2_e = 0;

    logic signed [15:0] coef_tb [TAPS];

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        in_valid = cur_v;
        fir_in   = cur_s;
        @(posedge clk);
        #1;
        check(sel ? "valid_s2" : "valid", sel ? out_valid2 : out_valid, q2_v);
        if (q2_v && q2_c)
            check(sel ? "data_s2" : "data", sel ? fir_out2 : fir_out, q2_e);
        q2_v = q1_v; q2_c = q1_c; q2_e = q1_e;
        q1_v = cur_v; q1_c = cur_care; q1_e = cur_ev;
    endtask

    task automatic start_load();
        flag = 1'b1;
        cyc();
        check("busy_rise", busy, 1);
        check("busy_rise_s2", busy2, 1);
    endtask

    // Last write shares its cycle with the falling flag
    task automatic write_bank(input int ev_after);
        for (int i = 0; i < TAPS; i++) begin
            csn = 1'b0; wrn = 1'b0; addr = 6'(i); wdata = coef_tb[i];
            if (i == TAPS - 1) begin
                flag = 1'b0;
                cur_ev = ev_after;
            end
            cyc();
        end
        csn = 1'b1;
        cyc();
        check("busy_fall", busy, 0);
    endtask

    task automatic load_all(input int ev_after);
        start_load();
        write_bank(ev_after);
    endtask

    initial begin
        int rc [5] = '{5, 6, -6, 6, -6};
        int rs [5] = '{1, 1, 1, 3, -1};
        int re [5] = '{1, 2, -1, 5, 2};

        repeat (2) @(posedge clk);
        #1;
        check("rst_out", fir_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_rd", rd_dt, 0);
        check("rst_err", addr_err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // Bus accesses in RUN are ignored
        csn = 1'b0; wrn = 1'b0; addr = 6'd0; wdata = 16'sd123;
        cyc();
        addr = 6'd40;
        cyc();
        check("run_no_err", addr_err, 0);
        csn = 1'b1;

        start_load();
        csn = 1'b0; wrn = 1'b1; addr = 6'd0;
        cyc();
        check("run_wr_ignored", rd_dt, 0);
        wrn = 1'b0; addr = 6'd5; wdata = 16'sd1234;
        cyc();
        wrn = 1'b1;
        cyc();
        check("readback", rd_dt, 1234);
        check("readback_s2", rd_dt2, 1234);
        csn = 1'b1;
        cyc();
        check("rd_hold", rd_dt, 1234);
        csn = 1'b0; wrn = 1'b0; addr = 6'd40; wdata = 16'sd999;
        cyc();
        check("addr_err", addr_err, 1);
        check("addr_err_s2", addr_err2, 1);
        wrn = 1'b1; addr = 6'd8;
        cyc();
        check("err_clear", addr_err, 0);
        check("no_alias", rd_dt, 0);
        for (int i = 0; i < TAPS; i++) coef_tb[i] = 16'(i + 1);
        write_bank(0);

        // Impulse: outputs 1..33 then 0
        cur_v = 1'b1; cur_care = 1'b1; cur_s = 3'sd1; cur_ev = 1;
        cyc();
        cur_s = 3'sd0;
        for (int m = 1; m <= 40; m++) begin
            cur_ev = (m < TAPS) ? m + 1 : 0;
            cyc();
        end
        cur_v = 1'b0; cur_care = 1'b0;
        repeat (3) cyc();

        // Saturation both ways; with n samples of -4 the sum is (99-7n)*32767
        for (int i = 0; i < TAPS; i++) coef_tb[i] = 16'sd32767;
        load_all(0);
        cur_v = 1'b1; cur_care = 1'b1; cur_s = 3'sd3; cur_ev = 32767;
        repeat (40) cyc();
        cur_s = -3'sd4;
        for (int j = 0; j < 40; j++) begin
            cur_ev = (j <= 13) ? 32767 : -32768;
            cyc();
        end
        cur_v = 1'b0; cur_care = 1'b0;
        repeat (3) cyc();
        check("hold", fir_out, -32768);

        // Round-half-up on the SHIFT=2 instance
        sel = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < TAPS; i++) coef_tb[i] = 16'sd0;
            coef_tb[0] = 16'(rc[k]);
            load_all(0);
            cur_v = 1'b1; cur_care = 1'b1; cur_s = 3'(rs[k]); cur_ev = re[k];
            repeat (3) cyc();
            cur_v = 1'b0; cur_care = 1'b0;
            repeat (2) cyc();
        end
        sel = 1'b0;

        // Live reload from all-1 to all-2 while streaming ones
        for (int i = 0; i < TAPS; i++) coef_tb[i] = 16'sd1;
        load_all(0);
        cur_v = 1'b1; cur_s = 3'sd1; cur_care = 1'b0;
        repeat (33) cyc();
        cur_care = 1'b1; cur_ev = 33;
        repeat (5) cyc();
        for (int i = 0; i < TAPS; i++) coef_tb[i] = 16'sd2;
        start_load();
        write_bank(66);
        repeat (6) cyc();

        // Asynchronous reset in the middle of a load while streaming
        start_load();
        csn = 1'b0; wrn = 1'b0; addr = 6'd0; wdata = 16'sd7;
        cyc();
        csn = 1'b1;
        #2;
        rst = 1'b1;
        flag = 1'b0;
        #1;
        check("arst_out", fir_out, 0);
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_rd", rd_dt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q1_v = 1'b0; q2_v = 1'b0;
        cur_care = 1'b1; cur_s = 3'sd1; cur_ev = 0;
        cyc();
        cur_s = 3'sd0;
        repeat (36) cyc();
        cur_v = 1'b0; cur_care = 1'b0;
        repeat (3) cyc();
        check("post_rst_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
